// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: one data-memory access at a time over a req/ack port, with pipeline stall,
// byte lanes and halt drain. Define MEM_TIMEOUT_EN to abort accesses that never see an ack.
module mem_stage_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_mem_inst,
  input  logic              mem_write_en,
  input  logic              is_word,
  input  logic              halted,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       read_data_2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              halt_done
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALTED} state_t;

  state_t            state_q, state_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d, load_data_d;
  logic [3:0]        mem_be_d;
  logic              load_valid_d, misalign_d, halt_done_d;
  logic              is_load_q, is_load_d;
  logic              word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic              halt_pend_q, halt_pend_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             bus_err_d;
`else
  assign bus_err = 1'b0;
`endif

  function automatic logic [31:0] select_load(input logic [31:0] rdata, input logic word,
                                              input logic [1:0] lane);
    if (word) return rdata;
    return {24'd0, rdata[8*lane +: 8]};
  endfunction

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_be_d     = mem_be;
    load_data_d  = load_data;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    halt_done_d  = halt_done;
    is_load_d    = is_load_q;
    word_d       = word_q;
    lane_d       = lane_q;
    halt_pend_d  = halt_pend_q;
`ifdef MEM_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A pending memory op takes priority over halt; the halt is remembered for DONE.
        if (is_mem_inst) begin
          stall       = 1'b1;
          halt_pend_d = halted;
          if (is_word && (alu_result[1:0] != 2'b00)) begin
            misalign_d  = 1'b1;
            load_data_d = 32'd0;
            state_d     = DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = mem_write_en;
            mem_addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
            mem_wdata_d = is_word ? read_data_2 : {4{read_data_2[7:0]}};
            mem_be_d    = is_word ? 4'b1111 : (4'b0001 << alu_result[1:0]);
            is_load_d   = ~mem_write_en;
            word_d      = is_word;
            lane_d      = alu_result[1:0];
            state_d     = ACCESS;
`ifdef MEM_TIMEOUT_EN
            to_cnt_d    = '0;
`endif
          end
        end else if (halted) begin
          halt_done_d = 1'b1;
          state_d     = HALTED;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_be_d  = 4'b0000;
          state_d   = DONE;
          if (is_load_q) begin
            load_data_d  = select_load(mem_rdata, word_q, lane_q);
            load_valid_d = 1'b1;
          end
        end
`ifdef MEM_TIMEOUT_EN
        // An ack on the limit cycle is taken by the branch above.
        else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d   = 1'b0;
          mem_be_d    = 4'b0000;
          load_data_d = 32'd0;
          bus_err_d   = 1'b1;
          state_d     = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (halt_pend_q) begin
          halt_done_d = 1'b1;
          state_d     = HALTED;
        end else begin
          state_d = IDLE;
        end
      end
      HALTED: begin
        halt_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      mem_be       <= 4'b0000;
      load_data    <= 32'd0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      halt_done    <= 1'b0;
      is_load_q    <= 1'b0;
      word_q       <= 1'b0;
      lane_q       <= 2'b00;
      halt_pend_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q     <= '0;
      bus_err      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_be       <= mem_be_d;
      load_data    <= load_data_d;
      load_valid   <= load_valid_d;
      misalign_err <= misalign_d;
      halt_done    <= halt_done_d;
      is_load_q    <= is_load_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      halt_pend_q  <= halt_pend_d;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      bus_err      <= bus_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases plus random access transactions checked against
// a cycle-timeline model of each access (detect, ACCESS cycles, DONE).
module tb_mem_stage_ctrl;
  localparam int ADDR_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              is_mem_inst, mem_write_en, is_word, halted;
  logic [ADDR_W-1:0] alu_result, mem_addr;
  logic [31:0]       read_data_2, mem_wdata, mem_rdata, load_data;
  logic              mem_req, mem_we, mem_ack, stall, load_valid, misalign_err, bus_err, halt_done;
  logic [3:0]        mem_be;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .is_mem_inst(is_mem_inst), .mem_write_en(mem_write_en),
    .is_word(is_word), .halted(halted), .alu_result(alu_result), .read_data_2(read_data_2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misalign_err(misalign_err),
    .bus_err(bus_err), .halt_done(halt_done)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    is_mem_inst = 1'b0; mem_write_en = 1'b0; is_word = 1'b0; halted = 1'b0;
    alu_result = '0; read_data_2 = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_req"}, 64'(mem_req), 64'd0);
    chk_val({tag, "_we"}, 64'(mem_we), 64'd0);
    chk_val({tag, "_be"}, 64'(mem_be), 64'd0);
    chk_val({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk_val({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk_val({tag, "_ldata"}, 64'(load_data), 64'd0);
    chk_val({tag, "_lvalid"}, 64'(load_valid), 64'd0);
    chk_val({tag, "_misal"}, 64'(misalign_err), 64'd0);
    chk_val({tag, "_buserr"}, 64'(bus_err), 64'd0);
    chk_val({tag, "_haltdone"}, 64'(halt_done), 64'd0);
    chk_val({tag, "_stall"}, 64'(stall), 64'd0);
  endtask

  task automatic idle_cycle();
    idle_inputs();
    #1;
    chk_val("idle_stall", 64'(stall), 64'd0);
    chk_val("idle_req", 64'(mem_req), 64'd0);
    chk_val("idle_lvalid", 64'(load_valid), 64'd0);
    chk_val("idle_misal", 64'(misalign_err), 64'd0);
    chk_val("idle_buserr", 64'(bus_err), 64'd0);
    @(negedge clk);
  endtask

  task automatic halted_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      is_mem_inst = 1'($urandom); halted = 1'($urandom); mem_write_en = 1'($urandom);
      is_word = 1'($urandom); alu_result = $urandom; mem_ack = 1'($urandom);
      #1;
      chk_val("halt_done", 64'(halt_done), 64'd1);
      chk_val("halt_stall", 64'(stall), 64'd0);
      chk_val("halt_req", 64'(mem_req), 64'd0);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // One access: n_acc is the ACCESS cycle on which ack arrives (1 = ack in the first one).
  task automatic do_access(input logic we, input logic word, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int n_acc,
                           input logic hlt);
    logic [1:0]  a;
    logic        misal, tmo;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld;
    int          n_run;
    a      = addr[1:0];
    misal  = word && (a != 2'b00);
    exp_be = word ? 4'hF : 4'(1 << a);
    exp_wd = word ? wd : {24'd0, wd[7:0]} * 32'h01010101;
    exp_ld = word ? rd : ((rd >> (8 * a)) & 32'hFF);
    n_run  = n_acc;
    tmo    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (n_acc > TIMEOUT_CYCLES) begin
      n_run = TIMEOUT_CYCLES;
      tmo   = 1'b1;
    end
`endif
    is_mem_inst = 1'b1; mem_write_en = we; is_word = word; alu_result = addr;
    read_data_2 = wd; halted = hlt; mem_ack = 1'b0;
    #1;
    chk_val("detect_stall", 64'(stall), 64'd1);
    chk_val("detect_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    if (!misal) begin
      for (int k = 1; k <= n_run; k++) begin
        mem_ack   = (k == n_acc);
        mem_rdata = (k == n_acc) ? rd : $urandom;
        #1;
        chk_val("acc_req", 64'(mem_req), 64'd1);
        chk_val("acc_stall", 64'(stall), 64'd1);
        chk_val("acc_addr", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
        chk_val("acc_be", 64'(mem_be), 64'(exp_be));
        chk_val("acc_we", 64'(mem_we), 64'(we));
        if (we) chk_val("acc_wdata", 64'(mem_wdata), 64'(exp_wd));
        @(negedge clk);
      end
    end
    // DONE: EX/MEM inputs are scrambled and must be ignored.
    mem_ack = 1'b0; mem_rdata = $urandom; is_mem_inst = 1'($urandom);
    mem_write_en = 1'($urandom); is_word = 1'($urandom); alu_result = $urandom;
    #1;
    chk_val("done_stall", 64'(stall), 64'd0);
    chk_val("done_req", 64'(mem_req), 64'd0);
    chk_val("done_be", 64'(mem_be), 64'd0);
    chk_val("done_lvalid", 64'(load_valid), 64'(!we && !misal && !tmo));
    if (!we && !misal && !tmo) chk_val("done_ldata", 64'(load_data), 64'(exp_ld));
    if (misal || tmo) chk_val("done_ldata_zero", 64'(load_data), 64'd0);
    chk_val("done_misal", 64'(misalign_err), 64'(misal));
    chk_val("done_buserr", 64'(bus_err), 64'(tmo));
    if (!hlt) chk_val("done_haltdone", 64'(halt_done), 64'd0);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1 chk_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    apply_reset();

    do_access(1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'h103, 32'h000000A5, 32'h0, 1, 1'b0);
    idle_cycle();
    do_access(1'b0, 1'b0, 32'h202, 32'h0, 32'h11223344, 3, 1'b0);
    idle_cycle();
    do_access(1'b0, 1'b1, 32'h105, 32'h0, 32'h0, 1, 1'b0);
    idle_cycle();

    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      do_access(1'($urandom), 1'($urandom), addr, $urandom, $urandom,
                int'($urandom_range(1, 6)), 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
    end

`ifdef MEM_TIMEOUT_EN
    do_access(1'b0, 1'b1, 32'h400, 32'h0, 32'h12345678, TIMEOUT_CYCLES + 2, 1'b0);
    idle_cycle();
    do_access(1'b0, 1'b1, 32'h404, 32'h0, 32'h87654321, TIMEOUT_CYCLES, 1'b0);
    idle_cycle();
`endif

    // Reset while a store is waiting for ack.
    is_mem_inst = 1'b1; mem_write_en = 1'b1; is_word = 1'b1;
    alu_result = 32'h540; read_data_2 = 32'hCAFEF00D;
    @(negedge clk);
    #1 chk_val("midrst_req_before", 64'(mem_req), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1 chk_reset_vals("midrst");
    rst_n = 1'b1;
    @(negedge clk);

    do_access(1'b1, 1'b1, 32'h300, 32'h5A5A1234, 32'h0, 2, 1'b1);
    halted_cycles(5);

    apply_reset();
    halted = 1'b1;
    #1 chk_val("halt_idle_stall", 64'(stall), 64'd0);
    @(negedge clk);
    halted_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
